vec_dot_collector: RTL and testbench
====================================

// Module: vec_dot_collector
// PURPOSE
//  Consumer end of the element-index stream that drives the vector multiplier.
//  - Takes one signed product per beat, tagged with its element index (0..VEC_LEN-1).
//  - Checks that indices arrive in order.
//  - Accumulates the products into a dot-product result.
//  - Presents the result on a valid/ready output handshake to the downstream result writer.
// PARAMETERS
//  VEC_LEN  64                       elements per vector; index runs 0..VEC_LEN-1
//  DATA_W   16                       width of signed product input
//  IDX_W    7                        width of element index, matches index counter
//  ACC_W    DATA_W+$clog2(VEC_LEN)   accumulator/result width (22), overflow-free
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous reset, active-high
//  in_valid   in   1       product beat present
//  in_ready   out  1       collector accepts beat (beat taken when in_valid & in_ready)
//  in_idx     in   IDX_W   element index of beat
//  in_data    in   DATA_W  signed product
//  out_valid  out  1       dot-product result available
//  out_ready  in   1       downstream takes result
//  out_data   out  ACC_W   signed dot-product result
//  busy       out  1       high in ACCUM or HOLD
//  err_seq    out  1       one-cycle pulse on index-sequence violation
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, acc=0, exp_idx=0.
//   Outputs during/after reset: out_valid=0, out_data=0, busy=0, err_seq=0, in_ready=1.
//   Reset mid-vector discards partial sum; no output is produced.
//  States: IDLE, ACCUM, HOLD.
//   - in_ready = (state != HOLD).
//   - busy = (state != IDLE).
//  IDLE:
//   - Beat with in_idx==0: acc <= sext(in_data), exp_idx <= 1, go ACCUM.
//   - If VEC_LEN==1, go HOLD instead.
//   - Beat with in_idx!=0: dropped, err_seq pulses next cycle, stay IDLE.
//  ACCUM:
//   - Beat with in_idx==exp_idx: acc <= acc + sext(in_data), exp_idx++.
//   - If in_idx==VEC_LEN-1, go HOLD.
//   - Beat with wrong index: err_seq pulses, acc cleared, go IDLE. The offending beat is not
//     restarted even if in_idx==0.
//   - in_valid low: hold all state; gaps of any length allowed.
//  HOLD:
//   - out_valid=1, out_data=acc; both held stable until out_ready.
//   - out_valid & out_ready: go IDLE, acc<=0, out_valid drops next cycle.
//   - in_ready=0, so no beat is accepted in HOLD.
//  Latency: out_valid rises the cycle after the last beat (idx VEC_LEN-1) is accepted.
//  Throughput: one beat per cycle.
//   - Min vector period = VEC_LEN + 1 cycles with out_ready tied high (1 HOLD cycle).
//  Arithmetic:
//   - Two's complement; sign-extend DATA_W to ACC_W before each add.
//   - No saturation needed: ACC_W is sized so no overflow occurs.
//  out_data is registered (acc); it reads 0 outside HOLD.
//  err_seq is registered, a single pulse per violation.
// STRUCTURE
//  Shared package vec_mul_pkg holds:
//   - VEC_LEN, DATA_W, IDX_W, ACC_W;
//   - the collector state enum {IDLE, ACCUM, HOLD}.
//  These constants are shared with the index counter and the multiplier array.
//  One sub-module: dot_acc. It is the signed ACC_W accumulator register with clr/load/add
//  controls and async active-high reset.
//  The FSM, exp_idx counter and handshake logic live in vec_dot_collector.
// TESTING
//  1) Basic dot product: idx 0..63 back-to-back, in_data=1 each, out_ready=1
//     -> out_valid exactly 1 cycle after idx 63, out_data=64, then IDLE.
//  2) Extreme signed values: in_data=-32768 for all 64 -> out_data=-2097152 (22'h200000).
//     in_data=+32767 for all 64 -> out_data=2097088. No wrap in either case.
//  3) Back-pressure: out_ready=0 for 10 cycles after completion
//     -> out_valid/out_data stable and in_ready=0 for 10 cycles.
//     A new idx 0 beat is accepted only after the handshake.
//  4) Sequence error: idx 0,1,2,5 -> err_seq 1-cycle pulse after the idx 5 beat, state IDLE.
//     A following clean 0..63 vector sums correctly.
//  5) Gaps and IDLE error: in_valid toggles every other cycle -> same sum as test 1.
//     idx 3 in IDLE -> err_seq pulse, no state change.
//  6) Reset mid-vector: assert rst after idx 30
//     -> out_valid=0, busy=0, in_ready=1 immediately (async).
//     Next full vector result excludes the old partial sum.

Source files
------------

// File: rtl/vec_mul_pkg.sv
// Constants and collector state type shared by the index counter, multiplier array
// and dot-product collector.
package vec_mul_pkg;

  localparam int VEC_LEN = 64;
  localparam int DATA_W  = 16;
  localparam int IDX_W   = 7;
  localparam int ACC_W   = DATA_W + $clog2(VEC_LEN);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_HOLD
  } coll_state_t;

  function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_W-1:0] d);
    return {{(ACC_W - DATA_W){d[DATA_W-1]}}, d};
  endfunction

endpackage

// File: rtl/dot_acc.sv
// Signed ACC_W accumulator register with clear/load/add controls.
// The output is registered and updates one cycle after a control; clear has top priority.
module dot_acc
  import vec_mul_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_load,
  input  logic                    i_add,
  input  logic [DATA_W-1:0]       i_data,
  output logic signed [ACC_W-1:0] o_acc
);

  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_ext;

  assign w_ext = sext(i_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= w_ext;
    end else if (i_add) begin
      r_acc <= r_acc + w_ext;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/vec_dot_collector.sv
// Collects VEC_LEN in-order indexed products into a dot product; the result appears the cycle
// after the last beat and is held (input stalled) until the downstream handshake.
module vec_dot_collector
  import vec_mul_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IDX_W-1:0]        in_idx,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    busy,
  output logic                    err_seq
);

  coll_state_t             r_state;
  coll_state_t             w_next_state;
  logic [IDX_W-1:0]        r_exp_idx;
  logic                    r_err_seq;
  logic                    w_take;
  logic                    w_clr;
  logic                    w_load;
  logic                    w_add;
  logic                    w_err;
  logic signed [ACC_W-1:0] w_acc;

  assign in_ready  = (r_state != ST_HOLD);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_state == ST_HOLD);
  assign out_data  = out_valid ? w_acc : '0;
  assign err_seq   = r_err_seq;
  assign w_take    = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_exp_idx <= '0;
      r_err_seq <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_err_seq <= w_err;
      if (w_load) begin
        r_exp_idx <= IDX_W'(1);
      end else if (w_add) begin
        r_exp_idx <= r_exp_idx + IDX_W'(1);
      end else if (w_clr) begin
        r_exp_idx <= '0;
      end
    end
  end

  // A bad index while accumulating aborts the vector; the offending beat never restarts one.
  always_comb begin
    w_next_state = r_state;
    w_clr        = 1'b0;
    w_load       = 1'b0;
    w_add        = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_take) begin
          if (in_idx == '0) begin
            w_load       = 1'b1;
            w_next_state = (VEC_LEN == 1) ? ST_HOLD : ST_ACCUM;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      ST_ACCUM: begin
        if (w_take) begin
          if (in_idx == r_exp_idx) begin
            w_add = 1'b1;
            if (in_idx == LAST_IDX) begin
              w_next_state = ST_HOLD;
            end
          end else begin
            w_err        = 1'b1;
            w_clr        = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_clr        = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_clr        = 1'b1;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  dot_acc u_dot_acc (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_load (w_load),
    .i_add  (w_add),
    .i_data (in_data),
    .o_acc  (w_acc)
  );

endmodule

// File: tb/tb_vec_dot_collector.sv
// Bench for vec_dot_collector: directed vectors, a per-cycle reference model and literal checks.
module tb_vec_dot_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_idx = '0;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [21:0] out_data;
  logic        busy;
  logic        err_seq;

  int n_vec = 0;
  int n_bad = 0;
  bit done  = 1'b0;

  vec_dot_collector dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_idx    (in_idx),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .err_seq   (err_seq)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the vector in progress as plain integers.
  bit m_active = 1'b0;
  bit m_hold   = 1'b0;
  bit m_err    = 1'b0;
  int m_next   = 0;
  int m_sum    = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_hold   = 1'b0;
      m_err    = 1'b0;
      m_next   = 0;
      m_sum    = 0;
    end else begin
      m_err = 1'b0;
      if (m_hold) begin
        if (out_ready) begin
          m_hold   = 1'b0;
          m_active = 1'b0;
          m_sum    = 0;
        end
      end else if (in_valid) begin
        if (!m_active) begin
          if (int'(in_idx) == 0) begin
            m_active = 1'b1;
            m_sum    = int'($signed(in_data));
            m_next   = 1;
            m_hold   = (m_next == 64);
          end else begin
            m_err = 1'b1;
          end
        end else if (int'(in_idx) == m_next) begin
          m_sum  = m_sum + int'($signed(in_data));
          m_next = m_next + 1;
          m_hold = (m_next == 64);
        end else begin
          m_err    = 1'b1;
          m_active = 1'b0;
          m_sum    = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      logic [21:0] m_out;
      m_out = m_hold ? m_sum[21:0] : 22'h0;
      chk("model out_valid", 32'(out_valid), 32'(m_hold));
      chk("model out_data", 32'(out_data), 32'(m_out));
      chk("model busy", 32'(busy), 32'(m_active | m_hold));
      chk("model in_ready", 32'(in_ready), 32'(!m_hold));
      chk("model err_seq", 32'(err_seq), 32'(m_err));
    end
  end

  task automatic beat(input int idx, input int data);
    in_valid = 1'b1;
    in_idx   = idx[6:0];
    in_data  = data[15:0];
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input int data, input bit ramp, input bit gaps);
    for (int i = 0; i < 64; i++) begin
      beat(i, ramp ? i : data);
      if (gaps && i < 63) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset err_seq", 32'(err_seq), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1) all ones, back-to-back
    send_vec(1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1 out_valid", 32'(out_valid), 32'd1);
    chk("t1 out_data", 32'(out_data), 32'd64);
    @(negedge clk);
    chk("t1 idle after handshake", 32'(busy), 32'd0);

    // 2) extreme signed products
    @(posedge clk);
    #1;
    send_vec(-32768, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2 min sum", 32'(out_data), 32'h200000);
    @(posedge clk);
    #1;
    send_vec(32767, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2 max sum", 32'(out_data), 32'h1FFFC0);
    @(posedge clk);
    #1;

    // 3) back-pressure with an idx 0 beat waiting during HOLD
    out_ready = 1'b0;
    send_vec(3, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_idx   = 7'd0;
    in_data  = 16'd5;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3 held out_valid", 32'(out_valid), 32'd1);
      chk("t3 held out_data", 32'(out_data), 32'd192);
      chk("t3 held in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    for (int i = 1; i < 64; i++) beat(i, 5);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3 next vector sum", 32'(out_data), 32'd320);
    @(posedge clk);
    #1;

    // 4) sequence error then a clean ramp vector
    beat(0, 9);
    beat(1, 9);
    beat(2, 9);
    beat(5, 9);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4 err pulse", 32'(err_seq), 32'd1);
    chk("t4 idle after err", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t4 err single", 32'(err_seq), 32'd0);
    @(posedge clk);
    #1;
    send_vec(0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t4 ramp sum", 32'(out_data), 32'd2016);
    @(posedge clk);
    #1;

    // 5) gapped input, then a stray index in IDLE
    send_vec(1, 1'b0, 1'b1);
    @(negedge clk);
    chk("t5 gapped sum", 32'(out_data), 32'd64);
    @(posedge clk);
    #1;
    beat(3, 4);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5 idle err pulse", 32'(err_seq), 32'd1);
    chk("t5 idle stays idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // 6) async reset mid-vector
    for (int i = 0; i <= 30; i++) beat(i, 7);
    in_valid = 1'b0;
    chk("t6 busy before reset", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6 reset out_valid", 32'(out_valid), 32'd0);
    chk("t6 reset busy", 32'(busy), 32'd0);
    chk("t6 reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_vec(2, 1'b0, 1'b0);
    @(negedge clk);
    chk("t6 fresh sum", 32'(out_data), 32'd128);
    repeat (3) @(negedge clk);

    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
